// File: rtl/qdi_reg_bist.sv
// rtl/qdi_reg_bist.sv - built-in self-test engine for an e1of4 QDI register
// Issues LFSR-chosen read/write tokens and checks the register's e1of4 outputs against a model.
module qdi_reg_bist #(
  parameter int unsigned DW          = 4,
  parameter int unsigned NO_TOKENS   = 16,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned EXP_DEPTH   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  inout  wire             VDD,
  inout  wire             GND,
  input  logic            START,
  output logic [2*DW-1:0] Tx,
  input  logic            Txe,
  output logic [2:0]      Cx,
  input  logic            Cxe,
  input  logic [2*DW-1:0] Rx,
  output logic            Rxe,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [15:0]     TX_COUNT,
  output logic [15:0]     RX_COUNT,
  output logic [15:0]     ERR_COUNT
);

  localparam int unsigned  NG      = DW / 2;
  localparam int unsigned  AW      = $clog2(EXP_DEPTH);
  localparam logic [AW:0]  Q_ONE   = (AW+1)'(1);
  localparam logic [AW:0]  Q_FULL  = (AW+1)'(EXP_DEPTH);
  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [15:0]  TOK_MAX = 16'(NO_TOKENS);
  localparam logic [2:0]   C_RD    = 3'b001;
  localparam logic [2:0]   C_WR    = 3'b010;
  localparam logic [2:0]   C_WRRD  = 3'b100;

  typedef enum logic [2:0] {T_IDLE, T_GEN, T_WAIT_EN, T_SEND, T_RTZ, T_DRAIN} tx_state_e;
  typedef enum logic {R_READY, R_ACK} rx_state_e;

  tx_state_e       tstate_q, tstate_d;
  rx_state_e       rstate_q, rstate_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [DW-1:0]   model_q, model_d;
  logic [2:0]      tok_cx_q, tok_cx_d;
  logic [DW-1:0]   tok_data_q, tok_data_d;
  logic [2*DW-1:0] tx_q, tx_d;
  logic [2:0]      cx_q, cx_d;
  logic            rxe_q, rxe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     tx_cnt_q, tx_cnt_d;
  logic [15:0]     rx_cnt_q, rx_cnt_d;
  logic [15:0]     err_q, err_d;

  logic [SYNC_STAGES-1:0] txe_sync_q, cxe_sync_q;
  logic [2*DW-1:0]        rx_sync_q [SYNC_STAGES];
  logic                   txe_s, cxe_s;
  logic [2*DW-1:0]        rx_s;

  logic [DW-1:0]   q_mem [EXP_DEPTH];
  logic [AW-1:0]   q_wptr_q, q_rptr_q;
  logic [AW:0]     q_cnt_q;
  logic            q_push, q_pop, q_full, q_empty;
  logic [DW-1:0]   q_head;

  logic [2:0]      gen_cx;
  logic [DW-1:0]   gen_data;
  logic            gen_pushes;
  logic [15:0]     lfsr_next;
  logic            tok_writes, tok_pushes, start_clr;
  logic            rx_valid, rx_multi, rx_zero, err_inc;
  logic [DW-1:0]   rx_dec;
  logic            unused_supply;

  assign unused_supply = VDD ^ GND;

  function automatic logic [2*DW-1:0] encode(input logic [DW-1:0] v);
    logic [2*DW-1:0] r;
    r = '0;
    for (int g = 0; g < NG; g++) r[4*g +: 4] = 4'b0001 << v[2*g +: 2];
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      txe_sync_q <= '0;
      cxe_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rx_sync_q[i] <= '0;
    end else begin
      txe_sync_q   <= {txe_sync_q[SYNC_STAGES-2:0], Txe};
      cxe_sync_q   <= {cxe_sync_q[SYNC_STAGES-2:0], Cxe};
      rx_sync_q[0] <= Rx;
      for (int i = 1; i < SYNC_STAGES; i++) rx_sync_q[i] <= rx_sync_q[i-1];
    end
  end

  assign txe_s = txe_sync_q[SYNC_STAGES-1];
  assign cxe_s = cxe_sync_q[SYNC_STAGES-1];
  assign rx_s  = rx_sync_q[SYNC_STAGES-1];

  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    gen_cx = C_RD;
    case (lfsr_q[1:0])
      2'b01:   gen_cx = C_WR;
      2'b10:   gen_cx = C_WRRD;
      default: gen_cx = C_RD;
    endcase
  end

  // Wide data words wrap around the 16-bit LFSR so DW up to 16 still gets fresh bits.
  assign gen_data   = DW'({lfsr_q, lfsr_q} >> 2);
  assign gen_pushes = (gen_cx != C_WR);
  assign tok_writes = tok_cx_q[1] | tok_cx_q[2];
  assign tok_pushes = tok_cx_q[0] | tok_cx_q[2];

  assign q_full  = (q_cnt_q == Q_FULL);
  assign q_empty = (q_cnt_q == '0);
  assign q_head  = q_mem[q_rptr_q];

  always_comb begin
    rx_valid = 1'b1;
    rx_multi = 1'b0;
    rx_dec   = '0;
    for (int g = 0; g < NG; g++) begin
      if (!$onehot(rx_s[4*g +: 4]))  rx_valid = 1'b0;
      if (!$onehot0(rx_s[4*g +: 4])) rx_multi = 1'b1;
      rx_dec[2*g +: 2] = {rx_s[4*g+3] | rx_s[4*g+2], rx_s[4*g+3] | rx_s[4*g+1]};
    end
  end

  assign rx_zero = (rx_s == '0);

  always_comb begin
    tstate_d   = tstate_q;
    lfsr_d     = lfsr_q;
    model_d    = model_q;
    tok_cx_d   = tok_cx_q;
    tok_data_d = tok_data_q;
    tx_d       = tx_q;
    cx_d       = cx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    tx_cnt_d   = tx_cnt_q;
    q_push     = 1'b0;
    start_clr  = 1'b0;
    case (tstate_q)
      T_IDLE: begin
        if (START) begin
          start_clr = 1'b1;
          lfsr_d    = SEED;
          model_d   = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          tx_cnt_d  = '0;
          tstate_d  = T_GEN;
        end
      end
      T_GEN: begin
        if (!(gen_pushes && q_full)) begin
          tok_cx_d   = gen_cx;
          tok_data_d = gen_data;
          lfsr_d     = lfsr_next;
          tstate_d   = T_WAIT_EN;
        end
      end
      T_WAIT_EN: begin
        if (cxe_s && (txe_s || !tok_writes)) begin
          cx_d     = tok_cx_q;
          q_push   = tok_pushes;
          tx_cnt_d = tx_cnt_q + 16'd1;
          if (tok_writes) begin
            tx_d    = encode(tok_data_q);
            model_d = tok_data_q;
          end
          tstate_d = T_SEND;
        end
      end
      T_SEND: begin
        if (!cxe_s && (!txe_s || !tok_writes)) begin
          cx_d     = '0;
          tx_d     = '0;
          tstate_d = T_RTZ;
        end
      end
      T_RTZ: begin
        tstate_d = (tx_cnt_q < TOK_MAX) ? T_GEN : T_DRAIN;
      end
      T_DRAIN: begin
        if (q_empty && (rstate_q == R_READY)) begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          tstate_d = T_IDLE;
        end
      end
      default: tstate_d = T_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rxe_d    = rxe_q;
    rx_cnt_d = rx_cnt_q;
    err_d    = err_q;
    q_pop    = 1'b0;
    err_inc  = 1'b0;
    case (rstate_q)
      R_READY: begin
        // A multi-rail group is acknowledged like a token but never compared.
        if (rx_valid || rx_multi) begin
          rstate_d = R_ACK;
          rxe_d    = 1'b0;
          rx_cnt_d = rx_cnt_q + 16'd1;
          q_pop    = !q_empty;
          if (rx_multi || q_empty || (rx_dec != q_head)) err_inc = 1'b1;
        end
      end
      R_ACK: begin
        if (rx_zero) begin
          rstate_d = R_READY;
          rxe_d    = 1'b1;
        end
      end
      default: rstate_d = R_READY;
    endcase
    if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    if (start_clr) begin
      rx_cnt_d = '0;
      err_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tstate_q   <= T_IDLE;
      rstate_q   <= R_READY;
      lfsr_q     <= SEED;
      model_q    <= '0;
      tok_cx_q   <= '0;
      tok_data_q <= '0;
      tx_q       <= '0;
      cx_q       <= '0;
      rxe_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      err_q      <= '0;
      q_wptr_q   <= '0;
      q_rptr_q   <= '0;
      q_cnt_q    <= '0;
    end else begin
      tstate_q   <= tstate_d;
      rstate_q   <= rstate_d;
      lfsr_q     <= lfsr_d;
      model_q    <= model_d;
      tok_cx_q   <= tok_cx_d;
      tok_data_q <= tok_data_d;
      tx_q       <= tx_d;
      cx_q       <= cx_d;
      rxe_q      <= rxe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      err_q      <= err_d;
      if (q_push) q_wptr_q <= q_wptr_q + P_ONE;
      if (q_pop)  q_rptr_q <= q_rptr_q + P_ONE;
      case ({q_push, q_pop})
        2'b10:   q_cnt_q <= q_cnt_q + Q_ONE;
        2'b01:   q_cnt_q <= q_cnt_q - Q_ONE;
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end

  // The expected value pushed is the model before this token's write.
  always_ff @(posedge CLK) begin
    if (q_push) q_mem[q_wptr_q] <= model_q;
  end

  assign Tx        = tx_q;
  assign Cx        = cx_q;
  assign Rxe       = rxe_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = done_q & (err_q == 16'd0);
  assign TX_COUNT  = tx_cnt_q;
  assign RX_COUNT  = rx_cnt_q;
  assign ERR_COUNT = err_q;

endmodule

// File: tb/tb_qdi_reg_bist.sv
// tb/tb_qdi_reg_bist.sv - self-checking bench for qdi_reg_bist
// A behavioural e1of4 register answers the BIST; token stream and counters are checked against a model.
module tb_qdi_reg_bist;

  localparam int DW    = 4;
  localparam int NT    = 16;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2*DW-1:0] tx;
  logic [2*DW-1:0] rx = '0;
  logic [2:0]      cx;
  logic            txe = 1'b1, cxe = 1'b1;
  logic            rxe, busy, done, pass;
  logic [15:0]     txc, rxc, errc;
  wire             vdd;
  wire             gnd;
  assign vdd = 1'b1;
  assign gnd = 1'b0;

  qdi_reg_bist #(.DW(DW), .NO_TOKENS(NT), .SEED(SEED_V), .EXP_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .CLK(clk), .RESET(rst_n), .VDD(vdd), .GND(gnd), .START(start),
    .Tx(tx), .Txe(txe), .Cx(cx), .Cxe(cxe), .Rx(rx), .Rxe(rxe),
    .BUSY(busy), .DONE(done), .PASS(pass),
    .TX_COUNT(txc), .RX_COUNT(rxc), .ERR_COUNT(errc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference token stream from the LFSR rules: kind 0=read, 1=write, 2=write+read.
  int            exp_kind [NT];
  logic [DW-1:0] exp_data [NT];
  int            exp_reads;
  int            stall_at;

  function automatic logic [2*DW-1:0] enc(input logic [DW-1:0] v);
    logic [2*DW-1:0] r = '0;
    for (int g = 0; g < DW/2; g++) r = r | ((2*DW)'(1) << (4*g + ((v >> (2*g)) & 3)));
    return r;
  endfunction

  function automatic logic [DW-1:0] dec(input logic [2*DW-1:0] t);
    logic [DW-1:0] v = '0;
    for (int g = 0; g < DW/2; g++)
      for (int b = 0; b < 4; b++)
        if (t[4*g+b]) v = v | DW'(b << (2*g));
    return v;
  endfunction

  function automatic int kind_of(input logic [2:0] c);
    case (c)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic build_model();
    int l = int'(SEED_V);
    int pushes = 0;
    exp_reads = 0;
    stall_at  = NT;
    for (int i = 0; i < NT; i++) begin
      exp_kind[i] = ((l & 3) == 1) ? 1 : ((l & 3) == 2) ? 2 : 0;
      exp_data[i] = DW'(((l | (l << 16)) >> 2) & ((1 << DW) - 1));
      if (exp_kind[i] != 1) begin
        exp_reads++;
        if (pushes == DEPTH && stall_at == NT) stall_at = i;
        pushes++;
      end
      l = (l >> 1) | ((((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1) << 15);
    end
  endtask

  // Behavioural register under test with randomised handshake delays.
  bit              model_rx = 1'b1;
  bit              withhold = 1'b0;
  int              corrupt_at = 0;
  int              max_delay = 0;
  int              rstate = 0, ostate = 0, dly = 0, odly = 0, out_n = 0, rk;
  logic [DW-1:0]   reg_val = '0, rd, ov;
  logic [DW-1:0]   outq [$];
  int              seen_kind [$];
  logic [DW-1:0]   seen_data [$];
  logic [2:0]      first_cx;
  logic [2*DW-1:0] first_tx;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rstate = 0; ostate = 0; dly = 0; odly = 0; out_n = 0;
      reg_val = '0; outq.delete();
      cxe = 1'b1; txe = 1'b1;
      if (model_rx) rx = '0;
    end else begin
      if (dly > 0) dly--;
      else if (rstate == 0) begin
        if (cx != 3'b000) begin
          rk = kind_of(cx);
          rd = dec(tx);
          if (seen_kind.size() == 0) begin first_cx = cx; first_tx = tx; end
          seen_kind.push_back(rk);
          seen_data.push_back((rk == 0) ? '0 : rd);
          if (rk != 1) outq.push_back(reg_val);
          if (rk != 0) begin reg_val = rd; txe = 1'b0; end
          cxe = 1'b0;
          rstate = 1;
          dly = int'($urandom_range(0, max_delay));
        end
      end else if (cx == 3'b000 && tx == '0) begin
        cxe = 1'b1; txe = 1'b1; rstate = 0;
        dly = int'($urandom_range(0, max_delay));
      end
      if (model_rx) begin
        if (odly > 0) odly--;
        else case (ostate)
          0: if (!withhold && outq.size() > 0 && rxe) begin
               ov = outq.pop_front();
               out_n++;
               if (out_n == corrupt_at) ov[0] = ~ov[0];
               rx = enc(ov);
               ostate = 1;
               odly = int'($urandom_range(0, max_delay));
             end
          1: if (!rxe) begin rx = '0; ostate = 2; odly = int'($urandom_range(0, max_delay)); end
          default: if (rxe) ostate = 0;
        endcase
      end
    end
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic run_once(input int corrupt, input int maxd, input string tag);
    corrupt_at = corrupt; max_delay = maxd; out_n = 0; reg_val = '0;
    seen_kind.delete(); seen_data.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(tag);
  endtask

  task automatic check_seq(input string tag);
    int nmis = 0;
    check({tag, "_ntok"}, seen_kind.size(), NT);
    for (int i = 0; i < NT && i < seen_kind.size(); i++)
      if (seen_kind[i] != exp_kind[i] || (exp_kind[i] != 0 && seen_data[i] != exp_data[i])) nmis++;
    check({tag, "_seq"}, nmis, 0);
  endtask

  task automatic check_run(input string tag, input int exp_err, input bit exp_pass);
    check_seq(tag);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_txc"}, txc, NT);
    check({tag, "_rxc"}, rxc, exp_reads);
    check({tag, "_err"}, errc, exp_err);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int corrupt;
    int maxd;
    int exp_err;
    bit exp_pass;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   c, d, n;
    vecs[0] = '{0, 0, 0, 1'b1};
    vecs[1] = '{3, 0, 1, 1'b0};
    vecs[2] = '{0, 6, 0, 1'b1};
    vecs[3] = '{1, 4, 1, 1'b0};
    build_model();

    repeat (5) @(negedge clk);
    check("rst_tx", tx, 0);
    check("rst_cx", cx, 0);
    check("rst_rxe", rxe, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_counts", {txc, rxc | errc}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_once(vecs[i].corrupt, vecs[i].maxd, $sformatf("vec%0d", i));
      check_run($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_pass);
      if (i == 0) begin
        check("first_cx", first_cx, 3'b001 << exp_kind[0]);
        check("first_tx", first_tx, enc(exp_data[0]));
      end
    end

    for (int i = 0; i < 3; i++) begin
      c = int'($urandom_range(0, exp_reads));
      d = int'($urandom_range(0, 8));
      run_once(c, d, $sformatf("rnd%0d", i));
      check_run($sformatf("rnd%0d", i), (c != 0) ? 1 : 0, c == 0);
    end

    // Withheld outputs: the queue fills and the generator must stall.
    withhold = 1'b1;
    corrupt_at = 0; max_delay = 0; out_n = 0; reg_val = '0;
    seen_kind.delete(); seen_data.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (400) @(negedge clk);
    check("stall_txc", txc, stall_at);
    check("stall_busy", busy, stall_at < NT);
    check("stall_rxc", rxc, 0);
    withhold = 1'b0;
    wait_done("stall");
    check_run("stall", 0, 1'b1);

    // Multi-rail group seen while idle, with raw-to-Rxe latency.
    do_reset();
    model_rx = 1'b0;
    rx = 8'h03;
    repeat (SS) @(negedge clk);
    check("multi_rxe_early", rxe, 1);
    @(negedge clk);
    check("multi_rxe_low", rxe, 0);
    repeat (3) @(negedge clk);
    check("multi_err", errc, 1);
    rx = '0;
    repeat (SS + 2) @(negedge clk);
    check("multi_rxe_back", rxe, 1);
    check("multi_err_hold", errc, 1);

    // Valid token arriving with nothing expected.
    do_reset();
    rx = enc(4'h5);
    repeat (SS + 3) @(negedge clk);
    check("spont_err", errc, 1);
    check("spont_rxc", rxc, 1);
    check("spont_rxe", rxe, 0);
    rx = '0;
    repeat (SS + 2) @(negedge clk);
    check("spont_rxe_back", rxe, 1);
    model_rx = 1'b1;

    // Reset asserted while a token is on the rails, then a clean rerun.
    do_reset();
    corrupt_at = 0; max_delay = 2; out_n = 0; reg_val = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(cx != 3'b000 && txc == 16'd3) && n < 5000) begin @(negedge clk); n++; end
    check("send_reached", cx != 3'b000 && txc == 16'd3, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cx", cx, 0);
    check("mid_rst_tx", tx, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_txc", txc, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_once(0, 2, "rerun");
    check_run("rerun", 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
